// File: rtl/voice_allocator_if.sv
// Note-event handshake and voice-bank drive bundle between an event source and voice_allocator.
interface voice_allocator_if #(
  parameter int unsigned NUM_VOICES = 4
);
  logic                    ev_valid;
  logic                    ev_ready;
  logic [7:0]              ev_note;
  logic                    ev_on;
  logic                    all_off;
  logic [8*NUM_VOICES-1:0] voice_note;
  logic [NUM_VOICES-1:0]   voice_key_on;
  logic                    stolen;

  modport master (
    output ev_valid, ev_note, ev_on, all_off,
    input  ev_ready, voice_note, voice_key_on, stolen
  );

  modport slave (
    input  ev_valid, ev_note, ev_on, all_off,
    output ev_ready, voice_note, voice_key_on, stolen
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on events to free, matching or oldest voices and
// routes note-offs; scans one voice per cycle, then applies the decision.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 4
) (
  input logic               Clk,
  input logic               Reset,
  voice_allocator_if.slave  bus
);
  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StScan   = 2'd1;
  localparam logic [1:0] StApply  = 2'd2;
  localparam logic [1:0] StRetrig = 2'd3;
  localparam logic [AGE_W-1:0] AgeMax  = '1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_VOICES - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            note_q [NUM_VOICES];
  logic [7:0]            note_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] key_on_q, key_on_d;
  logic                  stolen_q, stolen_d;
  logic [7:0]            ev_note_q, ev_note_d;
  logic                  ev_on_q, ev_on_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  match_vld_q, match_vld_d;
  logic [IdxW-1:0]       match_q, match_d;
  logic                  free_vld_q, free_vld_d;
  logic [IdxW-1:0]       free_q, free_d;
  logic [IdxW-1:0]       oldest_q, oldest_d;
  logic [AGE_W-1:0]      oldest_age_q, oldest_age_d;
  logic [IdxW-1:0]       tgt_q, tgt_d;
  logic [8*NUM_VOICES-1:0] voice_note_flat;
  logic                  accept;

  assign bus.ev_ready = Reset && (state_q == StIdle) && !bus.all_off;
  assign accept       = bus.ev_valid && bus.ev_ready;

  always_comb begin
    state_d      = state_q;
    note_d       = note_q;
    age_d        = age_q;
    key_on_d     = key_on_q;
    stolen_d     = 1'b0;
    ev_note_d    = ev_note_q;
    ev_on_d      = ev_on_q;
    idx_d        = idx_q;
    match_vld_d  = match_vld_q;
    match_d      = match_q;
    free_vld_d   = free_vld_q;
    free_d       = free_q;
    oldest_d     = oldest_q;
    oldest_age_d = oldest_age_q;
    tgt_d        = tgt_q;
    if (bus.all_off) begin
      key_on_d = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) age_d[i] = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ev_note_d   = bus.ev_note;
            ev_on_d     = bus.ev_on;
            idx_d       = '0;
            match_vld_d = 1'b0;
            free_vld_d  = 1'b0;
            state_d     = StScan;
          end
        end
        StScan: begin
          if (key_on_q[idx_q] && (note_q[idx_q] == ev_note_q) && !match_vld_q) begin
            match_vld_d = 1'b1;
            match_d     = idx_q;
          end
          if (!key_on_q[idx_q] && !free_vld_q) begin
            free_vld_d = 1'b1;
            free_d     = idx_q;
          end
          // Strict '>' keeps the lowest index on age ties.
          if ((idx_q == '0) || (age_q[idx_q] > oldest_age_q)) begin
            oldest_d     = idx_q;
            oldest_age_d = age_q[idx_q];
          end
          if (idx_q == LastIdx) state_d = StApply;
          else                  idx_d   = idx_q + IdxW'(1);
        end
        StApply: begin
          state_d = StIdle;
          if (!ev_note_q[7]) begin
            if (ev_on_q) begin
              if (match_vld_q) begin
                tgt_d             = match_q;
                key_on_d[match_q] = 1'b0;
                state_d           = StRetrig;
              end else if (free_vld_q) begin
                tgt_d            = free_q;
                note_d[free_q]   = ev_note_q;
                key_on_d[free_q] = 1'b1;
              end else begin
                tgt_d              = oldest_q;
                note_d[oldest_q]   = ev_note_q;
                key_on_d[oldest_q] = 1'b0;
                stolen_d           = 1'b1;
                state_d            = StRetrig;
              end
              for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (IdxW'(i) == tgt_d) age_d[i] = '0;
                else if (key_on_q[i] && (age_q[i] != AgeMax)) age_d[i] = age_q[i] + AGE_W'(1);
              end
            end else if (match_vld_q) begin
              key_on_d[match_q] = 1'b0;
            end
          end
        end
        StRetrig: begin
          // Gate was dropped for exactly one cycle in APPLY so the envelope restarts.
          key_on_d[tgt_q] = 1'b1;
          state_d         = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= StIdle;
      key_on_q     <= '0;
      stolen_q     <= 1'b0;
      ev_note_q    <= '0;
      ev_on_q      <= 1'b0;
      idx_q        <= '0;
      match_vld_q  <= 1'b0;
      match_q      <= '0;
      free_vld_q   <= 1'b0;
      free_q       <= '0;
      oldest_q     <= '0;
      oldest_age_q <= '0;
      tgt_q        <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      key_on_q     <= key_on_d;
      stolen_q     <= stolen_d;
      ev_note_q    <= ev_note_d;
      ev_on_q      <= ev_on_d;
      idx_q        <= idx_d;
      match_vld_q  <= match_vld_d;
      match_q      <= match_d;
      free_vld_q   <= free_vld_d;
      free_q       <= free_d;
      oldest_q     <= oldest_d;
      oldest_age_q <= oldest_age_d;
      tgt_q        <= tgt_d;
      note_q       <= note_d;
      age_q        <= age_d;
    end
  end

  always_comb begin
    voice_note_flat = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) voice_note_flat[8*i +: 8] = note_q[i];
  end

  assign bus.voice_note   = voice_note_flat;
  assign bus.voice_key_on = key_on_q;
  assign bus.stolen       = stolen_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, hand-written all_off/reset sequences and
// randomized events checked against a behavioural allocation model.
module tb_voice_allocator;
  localparam int NV = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  voice_allocator_if #(.NUM_VOICES(NV)) vif ();

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (vif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_note [NV];
  logic       m_on   [NV];
  int         m_age  [NV];

  typedef struct {
    bit         rst;
    logic [7:0] note;
    bit         on;
    logic [3:0] key;
    int         lat;
    int         st;
    int         voice;
    logic [7:0] vnote;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 8'd0;
      m_on[i]   = 1'b0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_all_off();
    for (int i = 0; i < NV; i++) begin
      m_on[i]  = 1'b0;
      m_age[i] = 0;
    end
  endtask

  // Allocation rules: match retriggers, else lowest free voice, else steal the oldest.
  task automatic model_event(input logic [7:0] n, input logic on,
                             output int exp_st, output int exp_rt, output int t);
    int match;
    int free;
    int old;
    match = -1; free = -1; old = 0;
    exp_st = 0; exp_rt = 0; t = -1;
    if (n[7]) return;
    for (int i = 0; i < NV; i++) begin
      if (m_on[i] && m_note[i] == n && match < 0) match = i;
      if (!m_on[i] && free < 0) free = i;
      if (m_age[i] > m_age[old]) old = i;
    end
    if (!on) begin
      if (match >= 0) m_on[match] = 1'b0;
      return;
    end
    if (match >= 0) begin
      t = match; exp_rt = 1;
    end else if (free >= 0) begin
      t = free;
    end else begin
      t = old; exp_rt = 1; exp_st = 1;
    end
    for (int i = 0; i < NV; i++) begin
      if (i == t) m_age[i] = 0;
      else if (m_on[i] && m_age[i] < 15) m_age[i]++;
    end
    m_note[t] = n;
    m_on[t]   = 1'b1;
  endtask

  task automatic compare_model(input string tag);
    logic [8*NV-1:0] en;
    logic [NV-1:0]   ek;
    for (int i = 0; i < NV; i++) begin
      en[8*i +: 8] = m_note[i];
      ek[i]        = m_on[i];
    end
    check({tag, "_notes"}, 64'(vif.voice_note), 64'(en));
    check({tag, "_key_on"}, 64'(vif.voice_key_on), 64'(ek));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    vif.ev_valid = 1'b0; vif.all_off = 1'b0; vif.ev_note = 8'd0; vif.ev_on = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("rst_notes", 64'(vif.voice_note), 64'd0);
    check("rst_key_on", 64'(vif.voice_key_on), 64'd0);
    check("rst_stolen", 64'(vif.stolen), 64'd0);
    check("rst_ready", 64'(vif.ev_ready), 64'd0);
    Reset = 1'b1;
    model_reset();
  endtask

  // Returns after the accepting posedge (ok=1), or flags a timeout.
  task automatic start_event(input logic [7:0] n, input logic on, output bit ok);
    int waited;
    waited = 0;
    @(negedge Clk);
    vif.ev_valid = 1'b1; vif.ev_note = n; vif.ev_on = on;
    while (!vif.ev_ready && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    ok = vif.ev_ready;
    if (!ok) begin
      check("accept_ready", 64'(vif.ev_ready), 64'd1);
      vif.ev_valid = 1'b0;
    end else begin
      @(posedge Clk);
    end
  endtask

  task automatic run_event(input logic [7:0] n, input logic on, input int t,
                           output int lat, output int st_cnt, output int low_t);
    bit ok;
    lat = 0; st_cnt = 0; low_t = 0;
    start_event(n, on, ok);
    if (!ok) return;
    forever begin
      @(negedge Clk);
      vif.ev_valid = 1'b0;
      if (vif.stolen) st_cnt++;
      if (t >= 0 && !vif.voice_key_on[t]) low_t++;
      if (vif.ev_ready) break;
      lat++;
      if (lat > 20) begin
        check("done_ready", 64'(vif.ev_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic add(input bit rst, input logic [7:0] note, input bit on, input logic [3:0] key,
                     input int lat, input int st, input int voice, input logic [7:0] vnote);
    vec_t v;
    v.rst = rst; v.note = note; v.on = on; v.key = key;
    v.lat = lat; v.st = st; v.voice = voice; v.vnote = vnote;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_st, exp_rt, t, lat, st_cnt, low_t;
    bit ok;
    logic [7:0] n;
    logic on;

    vif.ev_valid = 1'b0; vif.ev_note = 8'd0; vif.ev_on = 1'b0; vif.all_off = 1'b0;
    model_reset();

    add(1, 8'd60,  1, 4'b0001, 5, 0, 0, 8'd60);
    add(0, 8'd62,  1, 4'b0011, 5, 0, 1, 8'd62);
    add(0, 8'd64,  1, 4'b0111, 5, 0, 2, 8'd64);
    add(0, 8'd65,  1, 4'b1111, 5, 0, 3, 8'd65);
    add(0, 8'd62,  0, 4'b1101, 5, 0, 1, 8'd62);
    add(0, 8'd67,  1, 4'b1111, 5, 0, 1, 8'd67);
    add(1, 8'd60,  1, 4'b0001, 5, 0, 0, 8'd60);
    add(0, 8'd62,  1, 4'b0011, 5, 0, 1, 8'd62);
    add(0, 8'd64,  1, 4'b0111, 5, 0, 2, 8'd64);
    add(0, 8'd65,  1, 4'b1111, 5, 0, 3, 8'd65);
    add(0, 8'd67,  1, 4'b1111, 6, 1, 0, 8'd67);
    add(0, 8'd69,  1, 4'b1111, 6, 1, 1, 8'd69);
    add(0, 8'd71,  1, 4'b1111, 6, 1, 2, 8'd71);
    add(1, 8'd60,  1, 4'b0001, 5, 0, 0, 8'd60);
    add(0, 8'd60,  1, 4'b0001, 6, 0, 0, 8'd60);
    add(1, 8'd70,  0, 4'b0000, 5, 0, 0, 8'd0);
    add(0, 8'd200, 1, 4'b0000, 5, 0, 0, 8'd0);
    add(0, 8'd60,  1, 4'b0001, 5, 0, 0, 8'd60);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) do_reset();
      model_event(tbl[k].note, tbl[k].on, exp_st, exp_rt, t);
      run_event(tbl[k].note, tbl[k].on, t, lat, st_cnt, low_t);
      check($sformatf("vec%0d_key_on", k), 64'(vif.voice_key_on), 64'(tbl[k].key));
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'(tbl[k].lat));
      check($sformatf("vec%0d_stolen", k), 64'(st_cnt), 64'(tbl[k].st));
      check($sformatf("vec%0d_note", k), 64'(vif.voice_note[8*tbl[k].voice +: 8]),
            64'(tbl[k].vnote));
      if (tbl[k].lat == 6) check($sformatf("vec%0d_low_cycles", k), 64'(low_t), 64'd1);
      compare_model($sformatf("vec%0d", k));
    end

    // all_off during SCAN with three voices held
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n = 8'(60 + 2 * k);
      model_event(n, 1'b1, exp_st, exp_rt, t);
      run_event(n, 1'b1, t, lat, st_cnt, low_t);
    end
    compare_model("aoff_pre");
    start_event(8'd65, 1'b1, ok);
    @(negedge Clk); vif.ev_valid = 1'b0;
    @(negedge Clk);
    vif.all_off = 1'b1;
    @(negedge Clk);
    check("aoff_key_on", 64'(vif.voice_key_on), 64'd0);
    check("aoff_ready", 64'(vif.ev_ready), 64'd0);
    vif.all_off = 1'b0;
    model_all_off();
    st_cnt = 0; low_t = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      if (vif.stolen) st_cnt++;
      if (vif.voice_key_on != 4'b0000) low_t++;
    end
    check("aoff_no_stolen", 64'(st_cnt), 64'd0);
    check("aoff_stays_off", 64'(low_t), 64'd0);
    check("aoff_ready_back", 64'(vif.ev_ready), 64'd1);
    compare_model("aoff_post");
    model_event(8'd70, 1'b1, exp_st, exp_rt, t);
    run_event(8'd70, 1'b1, t, lat, st_cnt, low_t);
    check("aoff_next_latency", 64'(lat), 64'd5);
    compare_model("aoff_next");

    // reset pulse while in APPLY
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n = 8'(60 + 2 * k);
      model_event(n, 1'b1, exp_st, exp_rt, t);
      run_event(n, 1'b1, t, lat, st_cnt, low_t);
    end
    start_event(8'd64, 1'b1, ok);
    @(negedge Clk); vif.ev_valid = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rapply_notes", 64'(vif.voice_note), 64'd0);
    check("rapply_key_on", 64'(vif.voice_key_on), 64'd0);
    check("rapply_stolen", 64'(vif.stolen), 64'd0);
    check("rapply_ready_low", 64'(vif.ev_ready), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("rapply_ready_high", 64'(vif.ev_ready), 64'd1);
    model_reset();

    // randomized events against the model
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) n = 8'(128 + $urandom_range(0, 127));
      else                           n = 8'(60 + $urandom_range(0, 7));
      on = ($urandom_range(0, 2) != 0);
      model_event(n, on, exp_st, exp_rt, t);
      run_event(n, on, t, lat, st_cnt, low_t);
      check($sformatf("rnd%0d_latency", k), 64'(lat), 64'(exp_rt ? 6 : 5));
      check($sformatf("rnd%0d_stolen", k), 64'(st_cnt), 64'(exp_st));
      if (exp_rt != 0) check($sformatf("rnd%0d_low_cycles", k), 64'(low_t), 64'd1);
      compare_model($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
